adc_trigger_capture: RTL
========================

Name: adc_trigger_capture

Overview:
Downstream of the AD9284 LVDS input stage. Consumes parallel 8-bit ADC samples that are already retimed to CLK. Stores them in a circular block-RAM buffer with a programmable pre-trigger depth and arms on a threshold crossing. After the post-trigger fill it streams the frozen record out over a valid/ready interface to the readout logic, with LED-ready status outputs.

Parameters:
DATA_W, 8, sample width (AD9284 offset-binary, treated as unsigned)
DEPTH_LOG2, 10, log2 of record length; DEPTH = 2**DEPTH_LOG2 samples
PRE_TRIG, 64, samples kept before the trigger sample; legal range 0..DEPTH-1

Ports:
CLK  in  1  system clock; sole clock of the block
RST  in  1  synchronous, active-high reset
sample_in  in  DATA_W  ADC sample, valid when sample_valid=1
sample_valid  in  1  sample strobe (may be continuous or gapped)
arm  in  1  one-cycle start request, accepted only in IDLE
trig_level  in  DATA_W  threshold (driven from Switch)
trig_rising  in  1  1 = rising crossing, 0 = falling crossing
force_trig  in  1  immediate trigger, honoured only in ARMED
rd_data  out  DATA_W  readout sample
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
rd_last  out  1  marks final sample of record
busy  out  1  high in any state except IDLE
triggered  out  1  high from trigger until return to IDLE
state_o  out  3  encoded FSM state for LEDs

Behaviour:
- Interface: one clock CLK; RST is synchronous, active-high.
- Reset: state=IDLE. rd_data=0, rd_valid=0, rd_last=0, busy=0, triggered=0, state_o=0. Pointers and counters are cleared. RAM contents are not cleared.
- States and encodings: IDLE=0, PRETRIG=1, ARMED=2, POST=3, READOUT=4.
- IDLE: arm=1 goes to PRETRIG, clears wr_ptr, the pre count and prev_ok. arm is ignored in every other state.
- Capture states (PRETRIG, ARMED, POST):
  - Each valid sample is written to RAM[wr_ptr], then wr_ptr increments modulo DEPTH.
  - prev is set to sample_in and prev_ok is set to 1.
- PRETRIG: counts valid samples. After PRE_TRIG samples it goes to ARMED. PRE_TRIG=0 goes to ARMED on the cycle after arm.
- ARMED, trigger condition on a valid sample:
  - Rising: prev_ok & prev < trig_level & sample_in >= trig_level.
  - Falling: prev_ok & prev >= trig_level & sample_in < trig_level.
  - Unsigned compare.
- force_trig=1 in ARMED triggers on the current valid sample, or on the next valid sample if none is present that cycle.
- On trigger:
  - The triggering sample is written normally.
  - trig_ptr = wr_ptr of that sample.
  - triggered=1, then go to POST.
- ARMED with no trigger: the buffer wraps indefinitely; older samples are overwritten.
- POST: writes exactly DEPTH-PRE_TRIG-1 further valid samples, then goes to READOUT. If that count is 0, READOUT is entered the next cycle.
- READOUT: start address = (trig_ptr - PRE_TRIG) mod DEPTH. Exactly DEPTH samples are read in address order with wrap.
- RAM timing: synchronous read with 1-cycle latency. First rd_valid is no later than 2 cycles after entering READOUT.
- Handshake:
  - A transfer occurs when rd_valid & rd_ready.
  - While rd_valid=1 & rd_ready=0, rd_data and rd_last hold stable.
  - Back-to-back transfers at 1 sample/cycle are required when rd_ready is held high.
- rd_last=1 only with the DEPTH-th sample. After its transfer: rd_valid=0, triggered=0, state goes to IDLE.
- sample_valid is ignored in READOUT and IDLE; no writes occur.
- RST in any state aborts immediately to reset values. A new arm after reset works normally.
- trig_level and trig_rising are sampled live each cycle; changing them mid-capture takes effect on the next compare.

Test Plan:
- Bench settings: DEPTH_LOG2=4, PRE_TRIG=4. Ramp 0x00..0xFF continuous valid, trig_level=0x80, rising, arm, rd_ready=1 -> readout 0x7C..0x8B (16 samples), rd_last with 0x8B, then IDLE, busy=0.
- Falling trigger: ramp 0xFF downward, level 0x80, rising=0 -> trigger on 0x7F; readout 0x83..0x74, last=0x74.
- force_trig: samples constant 0x10, pulse force_trig 10 cycles after ARMED -> 16 samples of 0x10, triggered=1 during POST/READOUT.
- Backpressure: rd_ready toggles 1,0,0,1 repeating; gapped sample_valid 50% during capture -> same data as the first scenario, no drops or duplicates, rd_data stable while stalled.
- Ignored/abort: arm pulsed during POST -> no effect. RST asserted mid-READOUT -> next cycle all outputs 0, state_o=0. A re-arm then completes correctly.
- Edge cases:
  - PRE_TRIG=0: first readout sample is the trigger sample 0x80.
  - The very first sample after arm equal to 0x80 (prev_ok=0) does not trigger.

Source files
------------

// File: rtl/adc_trigger_capture.sv
// Circular pre/post-trigger capture buffer for 8-bit ADC samples. It arms on a
// threshold crossing or a forced trigger, then streams the frozen record out over valid/ready.
module adc_trigger_capture #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int PRE_TRIG   = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic              force_trig,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic [2:0]        state_o
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;
  localparam int AW     = DEPTH_LOG2;
  localparam int CW     = DEPTH_LOG2 + 1;
  localparam logic [AW-1:0] PRE_OFS = AW'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     trig_ptr_q, trig_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [AW-1:0]     post_cnt_q, post_cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_ok_q, prev_ok_d;
  logic              force_pend_q, force_pend_d;
  logic              triggered_q, triggered_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              busy_q, busy_d;
  logic [2:0]        state_o_q, state_o_d;

  logic              we;
  logic              rd_en;
  logic              rise_hit;
  logic              fall_hit;
  logic              trig_hit;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  // Handshake: a word moves when rd_valid & rd_ready at a rising CLK edge.
  // While rd_valid is high and rd_ready low, rd_data/rd_last hold; the RAM
  // read register is only reloaded when the output slot is empty or draining.
  assign rise_hit = prev_ok_q && (prev_q < trig_level) && (sample_in >= trig_level);
  assign fall_hit = prev_ok_q && (prev_q >= trig_level) && (sample_in < trig_level);
  assign trig_hit = force_trig || force_pend_q || (trig_rising ? rise_hit : fall_hit);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    trig_ptr_d   = trig_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    prev_d       = prev_q;
    prev_ok_d    = prev_ok_q;
    force_pend_d = force_pend_q;
    triggered_d  = triggered_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    we           = 1'b0;
    rd_en        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d      = S_PRETRIG;
          wr_ptr_d     = '0;
          pre_cnt_d    = '0;
          prev_ok_d    = 1'b0;
          force_pend_d = 1'b0;
        end
      end
      S_PRETRIG: begin
        if (sample_valid) begin
          we        = 1'b1;
          pre_cnt_d = pre_cnt_q + AW'(1);
        end
        if ((PRE_TRIG == 0) || (sample_valid && (int'(pre_cnt_q) + 1 >= PRE_TRIG))) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (sample_valid) begin
          we = 1'b1;
          if (trig_hit) begin
            trig_ptr_d   = wr_ptr_q;
            triggered_d  = 1'b1;
            post_cnt_d   = '0;
            force_pend_d = 1'b0;
            state_d      = S_POST;
          end
        end else if (force_trig) begin
          // Remember a force that arrived in a gap; it fires on the next sample.
          force_pend_d = 1'b1;
        end
      end
      S_POST: begin
        if (POST_N == 0) begin
          state_d  = S_READOUT;
          rd_ptr_d = trig_ptr_q - PRE_OFS;
          rd_cnt_d = '0;
        end else if (sample_valid) begin
          we         = 1'b1;
          post_cnt_d = post_cnt_q + AW'(1);
          if (int'(post_cnt_q) + 1 == POST_N) begin
            state_d  = S_READOUT;
            rd_ptr_d = trig_ptr_q - PRE_OFS;
            rd_cnt_d = '0;
          end
        end
      end
      S_READOUT: begin
        if (!rd_valid_q || rd_ready) begin
          if (rd_cnt_q == CW'(DEPTH)) begin
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
            triggered_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            rd_en      = 1'b1;
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_cnt_q == CW'(DEPTH - 1));
            rd_ptr_d   = rd_ptr_q + AW'(1);
            rd_cnt_d   = rd_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (we) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      prev_d    = sample_in;
      prev_ok_d = 1'b1;
    end

    busy_d    = (state_d != S_IDLE);
    state_o_d = state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      trig_ptr_q   <= '0;
      rd_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      force_pend_q <= 1'b0;
      triggered_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      state_o_q    <= 3'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      trig_ptr_q   <= trig_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      prev_q       <= prev_d;
      prev_ok_q    <= prev_ok_d;
      force_pend_q <= force_pend_d;
      triggered_q  <= triggered_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      busy_q       <= busy_d;
      state_o_q    <= state_o_d;
    end
  end

  // Block RAM: no reset on the array or its read register so it maps to BRAM.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[wr_ptr_q] <= sample_in;
    end
    if (rd_en) begin
      ram_q <= mem[rd_ptr_q];
    end
  end

  assign rd_data   = rd_valid_q ? ram_q : '0;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign state_o   = state_o_q;

endmodule
